// File: rtl/idex_pkg.sv
// idex_pkg: shared types and constants for the ID/EX pipeline register.
//   ex_ctrl_t   decoded control word carried into EX
//   ex_exc_t    exception-related flags carried into EX
//   BUBBLE_CTRL / BUBBLE_EXC  all-zero words: no writes, no memory access, no traps
//   IMM_KEEP_DEFAULT          low immediate bits stored in the register
package idex_pkg;

   localparam int unsigned IMM_KEEP_DEFAULT = 17;

   typedef struct packed {
      logic       Link;
      logic       ALUSrcImm;
      logic       RegDst;
      logic       LLSC;
      logic [4:0] ALUOp;
      logic       MemRead;
      logic       MemWrite;
      logic       MemHalf;
      logic       MemByte;
      logic       MemSignExtend;
      logic       RegWrite;
      logic       MemtoReg;
      logic       ReverseEndian;
   } ex_ctrl_t;

   typedef struct packed {
      logic KernelMode;
      logic IsBDS;
      logic Trap;
      logic TrapCond;
      logic EX_CanErr;
      logic M_CanErr;
   } ex_exc_t;

   localparam ex_ctrl_t BUBBLE_CTRL = '0;
   localparam ex_exc_t  BUBBLE_EXC  = '0;

endpackage

// File: rtl/intf_id.sv
// intf_id: signals published by the ID stage.
//   modport idex_in : consumed by idex_pipe_reg (all inputs)
//   modport id_out  : driven by the ID stage
//   ID_Stall, ID_Exception_Flush   request a bubble into EX
//   ID_Ctrl, ID_Exc                decoded control / exception flags
//   ID_RestartPC                   restart PC of the instruction in ID
//   Rs, Rt                         source register numbers
//   ID_ReadData1/2                 forwarded operands
//   ID_SignExtImm                  sign-extended immediate
interface intf_id;
   import idex_pkg::*;

   logic        ID_Stall;
   logic        ID_Exception_Flush;
   ex_ctrl_t    ID_Ctrl;
   ex_exc_t     ID_Exc;
   logic [31:0] ID_RestartPC;
   logic [4:0]  Rs;
   logic [4:0]  Rt;
   logic [31:0] ID_ReadData1;
   logic [31:0] ID_ReadData2;
   logic [31:0] ID_SignExtImm;

   modport idex_in (
      input ID_Stall, ID_Exception_Flush, ID_Ctrl, ID_Exc, ID_RestartPC, Rs, Rt,
            ID_ReadData1, ID_ReadData2, ID_SignExtImm
   );

   modport id_out (
      output ID_Stall, ID_Exception_Flush, ID_Ctrl, ID_Exc, ID_RestartPC, Rs, Rt,
             ID_ReadData1, ID_ReadData2, ID_SignExtImm
   );

endinterface

// File: rtl/idex_perf_cnt.sv
// idex_perf_cnt: two free-running wrap-around event counters.
//   clock         rising-edge clock
//   reset_n       synchronous active-low reset (counters cleared, no counting)
//   bubble_i      a bubble was written into EX this cycle
//   hold_i        EX held its contents this cycle
//   bubble_cnt_o  number of bubble cycles (wraps to 0)
//   hold_cnt_o    number of hold cycles (wraps to 0)
module idex_perf_cnt (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        bubble_i,
   input  logic        hold_i,
   output logic [31:0] bubble_cnt_o,
   output logic [31:0] hold_cnt_o
);

   logic [31:0] bubble_cnt_d, bubble_cnt_q;
   logic [31:0] hold_cnt_d, hold_cnt_q;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      if (bubble_i) bubble_cnt_d = bubble_cnt_q + 32'd1;
      if (hold_i)   hold_cnt_d   = hold_cnt_q + 32'd1;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         bubble_cnt_q <= '0;
         hold_cnt_q   <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
      end
   end

   assign bubble_cnt_o = bubble_cnt_q;
   assign hold_cnt_o   = hold_cnt_q;

endmodule

// File: rtl/idex_pipe_reg.sv
// idex_pipe_reg: ID/EX pipeline register with hold and bubble insertion.
// Optional feature: define IDEX_PERF_CNT_EN to add EX_BubbleCnt / EX_HoldCnt.
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   id                    intf_id.idex_in: ID-stage control, operands, Rs/Rt
//   EX_Stall              hold every register
//   EX_Exc_Flush          kill the EX instruction (wins over EX_Stall)
//   EX_Valid              register holds a real instruction
//   EX_Ctrl, EX_Exc       control / exception flags (all-zero in a bubble)
//   EX_RestartPC          restart PC for precise exceptions
//   EX_Rs, EX_Rt          source registers (0 in a bubble -> no forwarding match)
//   EX_Rd, EX_Shamt       fields of the stored immediate
//   EX_ReadData1/2        operands
//   EX_SignExtImm         stored IMM_KEEP bits re-extended to 32
//   EX_BubbleCnt/HoldCnt  event counters (IDEX_PERF_CNT_EN only)
module idex_pipe_reg
   import idex_pkg::*;
#(
   parameter int unsigned IMM_KEEP = IMM_KEEP_DEFAULT
) (
   input  logic          clock,
   input  logic          reset_n,
   intf_id.idex_in       id,
   input  logic          EX_Stall,
   input  logic          EX_Exc_Flush,
   output logic          EX_Valid,
   output ex_ctrl_t      EX_Ctrl,
   output ex_exc_t       EX_Exc,
   output logic [31:0]   EX_RestartPC,
   output logic [4:0]    EX_Rs,
   output logic [4:0]    EX_Rt,
   output logic [4:0]    EX_Rd,
   output logic [4:0]    EX_Shamt,
   output logic [31:0]   EX_ReadData1,
   output logic [31:0]   EX_ReadData2,
   output logic [31:0]   EX_SignExtImm
`ifdef IDEX_PERF_CNT_EN
   ,
   output logic [31:0]   EX_BubbleCnt,
   output logic [31:0]   EX_HoldCnt
`endif
);

   logic                valid_d, valid_q;
   ex_ctrl_t            ctrl_d, ctrl_q;
   ex_exc_t             exc_d, exc_q;
   logic [31:0]         pc_d, pc_q;
   logic [4:0]          rs_d, rs_q;
   logic [4:0]          rt_d, rt_q;
   logic [31:0]         rd1_d, rd1_q;
   logic [31:0]         rd2_d, rd2_q;
   logic [IMM_KEEP-1:0] imm_d, imm_q;
   logic                bubble;
   logic                hold;

   // Upper immediate bits are regenerated from the kept sign bit.
   logic unused_imm_hi;
   assign unused_imm_hi = ^id.ID_SignExtImm[31:IMM_KEEP];

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      exc_d   = exc_q;
      pc_d    = pc_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      rd1_d   = rd1_q;
      rd2_d   = rd2_q;
      imm_d   = imm_q;
      bubble  = 1'b0;
      hold    = 1'b0;

      // Flush beats stall so a faulting EX instruction dies even while EX waits.
      if (EX_Exc_Flush) begin
         bubble = 1'b1;
      end else if (EX_Stall) begin
         hold = 1'b1;
      end else if (id.ID_Stall | id.ID_Exception_Flush) begin
         bubble = 1'b1;
      end

      if (bubble) begin
         // Operand and immediate registers keep their last value in a bubble.
         valid_d = 1'b0;
         ctrl_d  = BUBBLE_CTRL;
         exc_d   = BUBBLE_EXC;
         pc_d    = '0;
         rs_d    = '0;
         rt_d    = '0;
      end else if (!hold) begin
         valid_d = 1'b1;
         ctrl_d  = id.ID_Ctrl;
         exc_d   = id.ID_Exc;
         pc_d    = id.ID_RestartPC;
         rs_d    = id.Rs;
         rt_d    = id.Rt;
         rd1_d   = id.ID_ReadData1;
         rd2_d   = id.ID_ReadData2;
         imm_d   = id.ID_SignExtImm[IMM_KEEP-1:0];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         ctrl_q  <= BUBBLE_CTRL;
         exc_q   <= BUBBLE_EXC;
         pc_q    <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         exc_q   <= exc_d;
         pc_q    <= pc_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         imm_q   <= imm_d;
      end
   end

   assign EX_Valid      = valid_q;
   assign EX_Ctrl       = ctrl_q;
   assign EX_Exc        = exc_q;
   assign EX_RestartPC  = pc_q;
   assign EX_Rs         = rs_q;
   assign EX_Rt         = rt_q;
   assign EX_ReadData1  = rd1_q;
   assign EX_ReadData2  = rd2_q;
   assign EX_SignExtImm = {{(32 - IMM_KEEP){imm_q[IMM_KEEP-1]}}, imm_q};
   assign EX_Rd         = EX_SignExtImm[15:11];
   assign EX_Shamt      = EX_SignExtImm[10:6];

`ifdef IDEX_PERF_CNT_EN
   idex_perf_cnt u_perf (
      .clock        (clock),
      .reset_n      (reset_n),
      .bubble_i     (bubble),
      .hold_i       (hold),
      .bubble_cnt_o (EX_BubbleCnt),
      .hold_cnt_o   (EX_HoldCnt)
   );
`endif

endmodule
